// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS control unit.
// Holds the controller state enum, opcode/funct constants, the ALU function
// encoding and the datapath mux-select encodings.
package mc_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC,
    S_ALU_WB, S_IMM_EXEC, S_IMM_WB, S_BRANCH, S_JUMP, S_JR, S_JAL
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [OP_W-1:0] FN_JR  = 6'b001000;
  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_NOR = 6'b100111;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  // ALU function encoding
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd5;

  // pc source select
  localparam logic [1:0] PC_ALU_RESULT = 2'b00;
  localparam logic [1:0] PC_ALU_OUT    = 2'b01;
  localparam logic [1:0] PC_JUMP       = 2'b10;
  localparam logic [1:0] PC_REG        = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // register-file write address select
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // register-file write data select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;
  localparam logic [1:0] WB_PC  = 2'b11;

  // immediate extend mode
  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: R-type funct to ALU function decode used in EXEC.
// Ports:
//   i_funct   in  6  instr[5:0]
//   o_alu_op  out 4  ALU function (mc_pkg encoding), ADD for unknown funct
//   o_legal   out 1  funct is a supported ALU operation
module mc_aludec
  import mc_pkg::*;
(
  input  logic [OP_W-1:0]     i_funct,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_legal
);

  always_comb begin
    o_alu_op = ALU_ADD;
    o_legal  = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_SLT:  o_alu_op = ALU_SLT;
      FN_NOR:  o_alu_op = ALU_NOR;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle main control unit for the MIPS core. Sequences
// the shared memory, ALU and register file over 3-5 cycles per instruction
// and holds memory requests until mem_ready.
// Optional feature: define MC_JAL_EN to decode jal (op 000011); otherwise it
// is illegal and reg_dst=10 / wb_sel=11 are never driven.
// Ports:
//   clk, rst                    clock, async active-high reset
//   op, funct, zero, mem_ready  instruction fields, ALU zero, memory done
//   mem_req, iord, mem_write    memory request, address select, write
//   ir_write, pc_write, pc_src  instruction register / pc load and source
//   reg_write, reg_dst, wb_sel  register-file write controls
//   alu_srca, alu_srcb, alu_op  ALU operand selects and function
//   ext_op                      immediate extend mode
//   illegal                     one-cycle pulse on unsupported op/funct
//   retired                     completed-instruction counter
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned RETIRED_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      op,
  input  logic [OP_W-1:0]      funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wb_sel,
  output logic                 alu_srca,
  output logic [1:0]           alu_srcb,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic [1:0]           ext_op,
  output logic                 illegal,
  output logic [RETIRED_W-1:0] retired
);

  state_t                r_state;
  state_t                w_next;
  logic                  w_retire;
  logic [RETIRED_W-1:0]  r_retired;
  logic [ALU_OP_W-1:0]   w_fn_alu_op;
  logic                  w_fn_legal;

  mc_aludec u_aludec (
    .i_funct  (funct),
    .o_alu_op (w_fn_alu_op),
    .o_legal  (w_fn_legal)
  );

  // State register and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + RETIRED_W'(1);
    end
  end

  assign retired = r_retired;

  // Next state and control decode; everything stays 0 while rst is high
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    mem_req   = 1'b0;
    iord      = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_ALU_RESULT;
    reg_write = 1'b0;
    reg_dst   = DST_RT;
    wb_sel    = WB_ALU;
    alu_srca  = 1'b0;
    alu_srcb  = SRCB_B;
    alu_op    = ALU_ADD;
    ext_op    = EXT_SIGN;
    illegal   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          alu_srcb = SRCB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end
        end
        S_DECODE: begin
          // Branch target computed speculatively into alu_out
          alu_srcb = SRCB_IMM_SH;
          case (op)
            OP_LW, OP_SW:                      w_next = S_MEM_ADR;
            OP_RTYPE:                          w_next = (funct == FN_JR) ? S_JR : S_EXEC;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IMM_EXEC;
            OP_LUI:                            w_next = S_IMM_WB;
            OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
            OP_J:                              w_next = S_JUMP;
`ifdef MC_JAL_EN
            OP_JAL:                            w_next = S_JAL;
`endif
            default: begin
              illegal = 1'b1;
              w_next  = S_FETCH;
            end
          endcase
        end
        S_MEM_ADR: begin
          alu_srca = 1'b1;
          alu_srcb = SRCB_IMM;
          w_next   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) w_next = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          wb_sel    = WB_MEM;
          w_next    = S_FETCH;
          w_retire  = 1'b1;
        end
        S_MEM_WR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end
        S_EXEC: begin
          alu_srca = 1'b1;
          alu_op   = w_fn_alu_op;
          if (w_fn_legal) begin
            w_next = S_ALU_WB;
          end else begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = DST_RD;
          w_next    = S_FETCH;
          w_retire  = 1'b1;
        end
        S_IMM_EXEC: begin
          alu_srca = 1'b1;
          alu_srcb = SRCB_IMM;
          case (op)
            OP_ANDI: begin alu_op = ALU_AND; ext_op = EXT_ZERO; end
            OP_ORI:  begin alu_op = ALU_OR;  ext_op = EXT_ZERO; end
            OP_SLTI: alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
          w_next = S_IMM_WB;
        end
        S_IMM_WB: begin
          reg_write = 1'b1;
          // lui writes the upper-extended immediate directly
          if (op == OP_LUI) begin
            wb_sel = WB_IMM;
            ext_op = EXT_UPPER;
          end
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
        S_BRANCH: begin
          alu_srca = 1'b1;
          alu_op   = ALU_SUB;
          pc_src   = PC_ALU_OUT;
          pc_write = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = PC_REG;
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
`ifdef MC_JAL_EN
        S_JAL: begin
          // Link and jump in the same cycle
          reg_write = 1'b1;
          reg_dst   = DST_RA;
          wb_sel    = WB_PC;
          pc_write  = 1'b1;
          pc_src    = PC_JUMP;
          w_next    = S_FETCH;
          w_retire  = 1'b1;
        end
`endif
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller. Each issued
// instruction expands into its expected per-cycle control words, queued by
// the stimulus; a monitor pops one word per cycle and compares.
module tb_mc_controller;
  import mc_pkg::*;

  localparam logic [5:0] T_R = 6'b000000, T_J = 6'b000010, T_JAL = 6'b000011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
  localparam logic [5:0] T_SLTI = 6'b001010, T_ANDI = 6'b001100, T_ORI = 6'b001101;
  localparam logic [5:0] T_LUI = 6'b001111, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_FJR = 6'b001000;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] op, funct;
  logic zero, mem_ready;
  logic mem_req, iord, mem_write, ir_write, pc_write, reg_write, alu_srca, illegal;
  logic [1:0] pc_src, reg_dst, wb_sel, alu_srcb, ext_op;
  logic [3:0] alu_op;
  logic [31:0] retired;

  mc_controller #(.RETIRED_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_op(alu_op), .ext_op(ext_op), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_req;
    logic        iord;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_sel;
    logic        alu_srca;
    logic [1:0]  alu_srcb;
    logic [3:0]  alu_op;
    logic [1:0]  ext_op;
    logic        illegal;
    logic [31:0] retired;
  } ctl_t;

  ctl_t        q_exp[$];
  string       q_name[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned exp_ret  = 0;

  // Monitor: one expected word per cycle, compared mid-cycle
  always @(negedge clk) begin
    ctl_t a, e;
    string nm;
    if (q_exp.size() > 0) begin
      a = '{mem_req, iord, mem_write, ir_write, pc_write, pc_src, reg_write,
            reg_dst, wb_sel, alu_srca, alu_srcb, alu_op, ext_op, illegal, retired};
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h required %h", nm, $time, a, e);
      end
    end
  end

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.retired = exp_ret;
    return c;
  endfunction

  task automatic cyc(input ctl_t c, input string nm, input logic rdy);
    mem_ready = rdy;
    q_exp.push_back(c);
    q_name.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic fetch(input int waits);
    ctl_t c = idle();
    c.mem_req  = 1'b1;
    c.alu_srcb = 2'b01;
    c.alu_op   = ALU_ADD;
    for (int i = 0; i < waits; i++) cyc(c, "fetch_wait", 1'b0);
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    cyc(c, "fetch", 1'b1);
  endtask

  task automatic rfn(input logic [5:0] f, output logic [3:0] a, output logic ok);
    ok = 1'b1;
    a  = ALU_ADD;
    case (f)
      6'b100000: a = ALU_ADD;
      6'b100010: a = ALU_SUB;
      6'b100100: a = ALU_AND;
      6'b100101: a = ALU_OR;
      6'b101010: a = ALU_SLT;
      6'b100111: a = ALU_NOR;
      default:   ok = 1'b0;
    endcase
  endtask

  // Reference: expected control words for one instruction, then retire count
  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int wf, input int wm);
    ctl_t c;
    logic [3:0] rop;
    logic rok, is_lw, is_sw, is_r, is_imm, is_lui, is_br, is_j, is_jal, legal;
    op = o; funct = f; zero = z;
    is_lw  = (o == T_LW);
    is_sw  = (o == T_SW);
    is_r   = (o == T_R);
    is_imm = (o == T_ADDI) || (o == T_ANDI) || (o == T_ORI) || (o == T_SLTI);
    is_lui = (o == T_LUI);
    is_br  = (o == T_BEQ) || (o == T_BNE);
    is_j   = (o == T_J);
`ifdef MC_JAL_EN
    is_jal = (o == T_JAL);
`else
    is_jal = 1'b0;
`endif
    legal = is_lw | is_sw | is_r | is_imm | is_lui | is_br | is_j | is_jal;
    fetch(wf);
    c = idle(); c.alu_srcb = 2'b11; c.illegal = !legal;
    cyc(c, "decode", rnd());
    if (!legal) return;
    if (is_lw || is_sw) begin
      c = idle(); c.alu_srca = 1'b1; c.alu_srcb = 2'b10;
      cyc(c, "mem_adr", rnd());
      c = idle(); c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = is_sw;
      for (int i = 0; i < wm; i++) cyc(c, "mem_wait", 1'b0);
      cyc(c, "mem_acc", 1'b1);
      if (is_lw) begin
        c = idle(); c.reg_write = 1'b1; c.wb_sel = 2'b01;
        cyc(c, "mem_wb", rnd());
      end
    end else if (is_r && f == T_FJR) begin
      c = idle(); c.pc_write = 1'b1; c.pc_src = 2'b11;
      cyc(c, "jr", rnd());
    end else if (is_r) begin
      rfn(f, rop, rok);
      c = idle(); c.alu_srca = 1'b1; c.alu_op = rop; c.illegal = !rok;
      cyc(c, "exec", rnd());
      if (!rok) return;
      c = idle(); c.reg_write = 1'b1; c.reg_dst = 2'b01;
      cyc(c, "alu_wb", rnd());
    end else if (is_imm) begin
      c = idle(); c.alu_srca = 1'b1; c.alu_srcb = 2'b10;
      c.alu_op = (o == T_ANDI) ? ALU_AND : (o == T_ORI) ? ALU_OR :
                 (o == T_SLTI) ? ALU_SLT : ALU_ADD;
      c.ext_op = (o == T_ANDI || o == T_ORI) ? 2'b01 : 2'b00;
      cyc(c, "imm_exec", rnd());
      c = idle(); c.reg_write = 1'b1;
      cyc(c, "imm_wb", rnd());
    end else if (is_lui) begin
      c = idle(); c.reg_write = 1'b1; c.wb_sel = 2'b10; c.ext_op = 2'b10;
      cyc(c, "lui_wb", rnd());
    end else if (is_br) begin
      c = idle(); c.alu_srca = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'b01;
      c.pc_write = (o == T_BEQ) ? z : !z;
      cyc(c, "branch", rnd());
    end else if (is_j) begin
      c = idle(); c.pc_write = 1'b1; c.pc_src = 2'b10;
      cyc(c, "jump", rnd());
    end else begin
      c = idle(); c.reg_write = 1'b1; c.reg_dst = 2'b10; c.wb_sel = 2'b11;
      c.pc_write = 1'b1; c.pc_src = 2'b10;
      cyc(c, "jal", rnd());
    end
    exp_ret++;
  endtask

  task automatic rand_instr();
    logic [5:0] o, f;
    int s;
    s = $urandom_range(0, 14);
    case (s)
      0: o = T_LW;   1: o = T_SW;   2: o = T_R;    3: o = T_R;
      4: o = T_ADDI; 5: o = T_ANDI; 6: o = T_ORI;  7: o = T_SLTI;
      8: o = T_LUI;  9: o = T_BEQ;  10: o = T_BNE; 11: o = T_J;
      12: o = T_JAL;
      default: o = 6'($urandom);
    endcase
    s = $urandom_range(0, 7);
    case (s)
      0: f = 6'b100000; 1: f = 6'b100010; 2: f = 6'b100100; 3: f = 6'b100101;
      4: f = 6'b101010; 5: f = 6'b100111; 6: f = T_FJR;
      default: f = 6'($urandom);
    endcase
    do_instr(o, f, rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  // Abandon a waiting store with reset; retired returns to 0
  task automatic reset_mid_store();
    ctl_t c;
    op = T_SW; funct = 6'd0; zero = 1'b0;
    fetch(0);
    c = idle(); c.alu_srcb = 2'b11;
    cyc(c, "decode", 1'b1);
    c = idle(); c.alu_srca = 1'b1; c.alu_srcb = 2'b10;
    cyc(c, "mem_adr", 1'b1);
    c = idle(); c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1;
    cyc(c, "mem_wait", 1'b0);
    cyc(c, "mem_wait", 1'b0);
    rst = 1'b1;
    exp_ret = 0;
    cyc('0, "reset_mid_store", 1'b1);
    cyc('0, "reset_hold", 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc('0, "reset", 1'b1);
    cyc('0, "reset", 1'b0);
    rst = 1'b0;
    do_instr(T_LW,   6'd0,      1'b0, 0, 0);
    do_instr(T_R,    6'b100000, 1'b0, 3, 0);
    do_instr(T_BEQ,  6'd0,      1'b1, 0, 0);
    do_instr(T_BNE,  6'd0,      1'b1, 0, 0);
    do_instr(T_BEQ,  6'd0,      1'b0, 0, 0);
    do_instr(T_BNE,  6'd0,      1'b0, 0, 0);
    do_instr(T_ORI,  6'd0,      1'b0, 0, 0);
    do_instr(T_LUI,  6'd0,      1'b0, 0, 0);
    do_instr(6'b111111, 6'd0,   1'b0, 0, 0);
    do_instr(T_R,    6'b111111, 1'b0, 0, 0);
    do_instr(T_SW,   6'd0,      1'b0, 1, 3);
    do_instr(T_R,    T_FJR,     1'b0, 0, 0);
    do_instr(T_J,    6'd0,      1'b0, 0, 0);
    do_instr(T_JAL,  6'd0,      1'b0, 0, 0);
    do_instr(T_LW,   6'd0,      1'b0, 2, 2);
    for (int k = 0; k < 300; k++) rand_instr();
    reset_mid_store();
    do_instr(T_LW,   6'd0,      1'b0, 0, 0);
    for (int k = 0; k < 20; k++) rand_instr();
    @(negedge clk);
    #1;
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d words left required 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
